// File: rtl/loader_pkg.sv
// Shared types and defaults for the instruction-memory loader.
// Image geometry falls back to these values when defines.v is not compiled first.
`ifndef NO_INSTR_BYTES
`define NO_INSTR_BYTES 16
`endif
`ifndef MEM_CELL_SIZE
`define MEM_CELL_SIZE 8
`endif

package loader_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    PAD  = 3'd2,
    HOLD = 3'd3,
    RUN  = 3'd4
  } loader_state_t;

  localparam int RST_HOLD_DEFAULT = 4;

endpackage

// File: rtl/loader_byte_steer.sv
// Maps the cells of one input beat onto ascending memory addresses.
// cells[k] is the cell destined for address base+k.
module loader_byte_steer #(
  parameter int IN_BYTES      = 4,
  parameter int MEM_CELL_SIZE = 8,
  parameter bit BIG_ENDIAN    = 1'b1
) (
  input  logic [IN_BYTES*MEM_CELL_SIZE-1:0]    in_data,
  output logic [IN_BYTES-1:0][MEM_CELL_SIZE-1:0] cells
);

  always_comb begin
    cells = '0;
    for (int k = 0; k < IN_BYTES; k++) begin
      if (BIG_ENDIAN)
        cells[k] = in_data[(IN_BYTES-1-k)*MEM_CELL_SIZE +: MEM_CELL_SIZE];
      else
        cells[k] = in_data[k*MEM_CELL_SIZE +: MEM_CELL_SIZE];
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// Streams an instruction image into a packed cell array, pads the tail with
// zero cells, then holds the processor in reset for RST_HOLD cycles.
//
// state | meaning
// IDLE  | no image, processor held in reset
// LOAD  | accepting input beats
// PAD   | filling unwritten tail with zero cells
// HOLD  | image complete, reset held RST_HOLD cycles
// RUN   | processor released, image frozen
module instr_mem_loader
  import loader_pkg::*;
#(
  parameter int NO_INSTR_BYTES = `NO_INSTR_BYTES,
  parameter int MEM_CELL_SIZE  = `MEM_CELL_SIZE,
  parameter int IN_BYTES       = 4,
  parameter bit BIG_ENDIAN     = 1'b1,
  parameter int RST_HOLD       = RST_HOLD_DEFAULT
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          start,
  input  logic                                          fwd_cfg,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic [IN_BYTES*MEM_CELL_SIZE-1:0]             in_data,
  input  logic                                          in_last,
  output logic [NO_INSTR_BYTES-1:0][MEM_CELL_SIZE-1:0]  instr_byte,
  output logic                                          cpu_rst,
  output logic                                          forwarding_EN,
  output logic                                          load_done,
  output logic                                          err_trunc,
  output logic [$clog2(NO_INSTR_BYTES+1)-1:0]           byte_count
);

  localparam int CW = $clog2(NO_INSTR_BYTES + 1);
  localparam int AW = (NO_INSTR_BYTES > 1) ? $clog2(NO_INSTR_BYTES) : 1;
  localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

  loader_state_t state, state_nxt;
  logic [CW-1:0] count_inc;
  logic [AW-1:0] base_addr;
  logic [HW-1:0] hold_cnt;
  logic          accept, full, wr_en, wr_zero;
  logic [IN_BYTES-1:0][MEM_CELL_SIZE-1:0] beat_cells;

  loader_byte_steer #(
    .IN_BYTES      (IN_BYTES),
    .MEM_CELL_SIZE (MEM_CELL_SIZE),
    .BIG_ENDIAN    (BIG_ENDIAN)
  ) u_steer (
    .in_data (in_data),
    .cells   (beat_cells)
  );

  assign in_ready  = (state == LOAD) && !start;
  assign accept    = in_valid && in_ready;
  assign count_inc = byte_count + CW'(IN_BYTES);
  assign full      = (count_inc == CW'(NO_INSTR_BYTES));
  assign base_addr = byte_count[AW-1:0];
  assign cpu_rst   = (state != RUN);
  assign load_done = (state == RUN);

  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    wr_zero   = 1'b0;
    case (state)
      IDLE: ;
      LOAD: begin
        if (accept) begin
          wr_en = 1'b1;
          if (full)
            state_nxt = HOLD;
          else if (in_last)
            state_nxt = PAD;
        end
      end
      PAD: begin
        wr_en   = 1'b1;
        wr_zero = 1'b1;
        if (full)
          state_nxt = HOLD;
      end
      HOLD: begin
        if (hold_cnt == '0)
          state_nxt = RUN;
      end
      RUN: ;
      default: state_nxt = IDLE;
    endcase
    // A restart overrides whatever the current state wanted to do.
    if (start) begin
      state_nxt = LOAD;
      wr_en     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      byte_count    <= '0;
      err_trunc     <= 1'b0;
      forwarding_EN <= 1'b0;
      hold_cnt      <= '0;
      instr_byte    <= '0;
    end else begin
      state <= state_nxt;
      if (start) begin
        byte_count    <= '0;
        err_trunc     <= 1'b0;
        forwarding_EN <= fwd_cfg;
      end else if (wr_en) begin
        byte_count <= count_inc;
        for (int k = 0; k < IN_BYTES; k++)
          instr_byte[base_addr + AW'(k)] <= wr_zero ? '0 : beat_cells[k];
        if ((state == LOAD) && full && !in_last)
          err_trunc <= 1'b1;
      end
      if (state != HOLD)
        hold_cnt <= HW'(RST_HOLD - 1);
      else if (hold_cnt != '0)
        hold_cnt <= hold_cnt - HW'(1);
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench for instr_mem_loader: big- and little-endian instances share stimulus;
// loaded images are checked against a fixed table and a cell scoreboard.
module tb_instr_mem_loader;

  localparam int N = 16;

  logic clk = 1'b0;
  logic rst, start, fwd_cfg, in_valid, in_last;
  logic [31:0] in_data;

  logic            be_ready, be_cpu_rst, be_fwd, be_done, be_err;
  logic [N-1:0][7:0] be_img;
  logic [4:0]      be_count;
  logic            le_ready, le_cpu_rst, le_fwd, le_done, le_err;
  logic [N-1:0][7:0] le_img;
  logic [4:0]      le_count;

  always #5 clk = ~clk;

  instr_mem_loader #(.NO_INSTR_BYTES(N), .MEM_CELL_SIZE(8), .IN_BYTES(4),
                     .BIG_ENDIAN(1'b1), .RST_HOLD(4)) u_be (
    .clk(clk), .rst(rst), .start(start), .fwd_cfg(fwd_cfg),
    .in_valid(in_valid), .in_ready(be_ready), .in_data(in_data), .in_last(in_last),
    .instr_byte(be_img), .cpu_rst(be_cpu_rst), .forwarding_EN(be_fwd),
    .load_done(be_done), .err_trunc(be_err), .byte_count(be_count));

  instr_mem_loader #(.NO_INSTR_BYTES(N), .MEM_CELL_SIZE(8), .IN_BYTES(4),
                     .BIG_ENDIAN(1'b0), .RST_HOLD(4)) u_le (
    .clk(clk), .rst(rst), .start(start), .fwd_cfg(fwd_cfg),
    .in_valid(in_valid), .in_ready(le_ready), .in_data(in_data), .in_last(in_last),
    .instr_byte(le_img), .cpu_rst(le_cpu_rst), .forwarding_EN(le_fwd),
    .load_done(le_done), .err_trunc(le_err), .byte_count(le_count));

  typedef struct {
    int         addr;
    logic [7:0] be;
    logic [7:0] le;
  } cell_t;

  cell_t sb[$];
  cell_t tbl[N];
  int wp;
  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_beat(input logic [31:0] d);
    for (int k = 0; k < 4; k++) begin
      cell_t c;
      c.addr = wp + k;
      c.be   = d[31-8*k -: 8];
      c.le   = d[8*k +: 8];
      sb.push_back(c);
    end
    wp += 4;
  endtask

  task automatic push_pad();
    while (wp < N) begin
      cell_t c;
      c.addr = wp;
      c.be   = 8'h00;
      c.le   = 8'h00;
      sb.push_back(c);
      wp++;
    end
  endtask

  task automatic check_sb(input string tag);
    while (sb.size() > 0) begin
      cell_t c;
      c = sb.pop_front();
      chk($sformatf("%s_be[%0d]", tag, c.addr), be_img[c.addr], c.be);
      chk($sformatf("%s_le[%0d]", tag, c.addr), le_img[c.addr], c.le);
    end
  endtask

  task automatic pulse_start(input logic f);
    start   = 1'b1;
    fwd_cfg = f;
    cyc();
    start = 1'b0;
    sb.delete();
    wp = 0;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(negedge clk);
    chk("in_ready_beat", be_ready, 1'b1);
    cyc();
    in_valid = 1'b0;
    in_last  = 1'b0;
    push_beat(d);
  endtask

  // Counts PAD-like (count below N) and HOLD cycles until cpu_rst drops.
  task automatic wait_run(output int pad_c, output int hold_c);
    pad_c  = 0;
    hold_c = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!be_cpu_rst) break;
      if (be_count < 5'(N)) pad_c++;
      else hold_c++;
    end
    chk("reach_run", be_cpu_rst, 1'b0);
  endtask

  initial begin
    int pad_c, hold_c;
    logic seen_done;
    logic [N-1:0][7:0] snap;

    tbl[0] = '{0, 8'h80, 8'h0A};
    tbl[1] = '{1, 8'h20, 8'h00};
    tbl[2] = '{2, 8'h00, 8'h20};
    tbl[3] = '{3, 8'h0A, 8'h80};
    tbl[4] = '{4, 8'h04, 8'h00};
    tbl[5] = '{5, 8'h40, 8'h08};
    tbl[6] = '{6, 8'h08, 8'h40};
    tbl[7] = '{7, 8'h00, 8'h04};
    for (int i = 8; i < N; i++) tbl[i] = '{i, 8'h00, 8'h00};

    rst = 1'b1; start = 1'b0; fwd_cfg = 1'b0;
    in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    wp = 0;
    repeat (2) cyc();
    @(negedge clk);
    chk("rst_cpu_rst", be_cpu_rst, 1'b1);
    chk("rst_in_ready", be_ready, 1'b0);
    chk("rst_load_done", be_done, 1'b0);
    chk("rst_err", be_err, 1'b0);
    chk("rst_count", be_count, 5'd0);
    chk("rst_fwd", be_fwd, 1'b0);
    chk("rst_img_zero", (be_img == '0 && le_img == '0), 1'b1);
    cyc();
    rst = 1'b0;

    // Beats in IDLE are ignored.
    in_valid = 1'b1; in_data = 32'hDEADBEEF; in_last = 1'b1;
    repeat (3) cyc();
    chk("idle_ready", be_ready, 1'b0);
    chk("idle_count", be_count, 5'd0);
    chk("idle_img", (be_img == '0), 1'b1);
    in_valid = 1'b0; in_last = 1'b0;

    // Two-beat image with padding.
    pulse_start(1'b1);
    send_beat(32'h8020000A, 1'b0);
    chk("count_after_beat1", be_count, 5'd4);
    send_beat(32'h04400800, 1'b1);
    push_pad();
    wait_run(pad_c, hold_c);
    chk("pad_cycles", pad_c, 2);
    chk("hold_cycles", hold_c, 4);
    chk("load_done_run", be_done, 1'b1);
    chk("le_load_done_run", le_done, 1'b1);
    chk("err_clean", be_err, 1'b0);
    chk("fwd_on", be_fwd, 1'b1);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("tbl_be[%0d]", tbl[i].addr), be_img[tbl[i].addr], tbl[i].be);
      chk($sformatf("tbl_le[%0d]", tbl[i].addr), le_img[tbl[i].addr], tbl[i].le);
    end
    check_sb("img1");

    // RUN keeps the image frozen and ignores input.
    snap = be_img;
    in_valid = 1'b1; in_data = 32'h12345678;
    repeat (3) cyc();
    in_valid = 1'b0;
    chk("run_stable", (be_img == snap), 1'b1);
    chk("run_count", be_count, 5'd16);

    // Restart from RUN with forwarding off.
    start = 1'b1; fwd_cfg = 1'b0;
    @(negedge clk);
    chk("restart_cpu_rst_same_cycle", be_cpu_rst, 1'b0);
    cyc();
    start = 1'b0;
    sb.delete(); wp = 0;
    chk("restart_fwd", be_fwd, 1'b0);
    chk("restart_cpu_rst", be_cpu_rst, 1'b1);
    chk("restart_load_done", be_done, 1'b0);
    chk("restart_count", be_count, 5'd0);
    chk("retain_cell0", be_img[0], 8'h80);

    // Beat dropped by a concurrent start, then a truncated four-beat image.
    send_beat(32'h11223344, 1'b0);
    in_valid = 1'b1; in_data = 32'h99AABBCC; start = 1'b1; fwd_cfg = 1'b0;
    @(negedge clk);
    chk("drop_in_ready", be_ready, 1'b0);
    cyc();
    start = 1'b0; in_valid = 1'b0;
    sb.delete(); wp = 0;
    chk("drop_count", be_count, 5'd0);
    send_beat(32'h55667788, 1'b0);
    send_beat(32'h01020304, 1'b0);
    send_beat(32'h05060708, 1'b0);
    send_beat(32'h090A0B0C, 1'b0);
    chk("trunc_in_ready", be_ready, 1'b0);
    chk("trunc_err", be_err, 1'b1);
    chk("trunc_count", be_count, 5'd16);
    wait_run(pad_c, hold_c);
    chk("trunc_pad_cycles", pad_c, 0);
    chk("trunc_hold_cycles", hold_c, 4);
    chk("trunc_load_done", be_done, 1'b1);
    chk("trunc_err_run", be_err, 1'b1);
    chk("addr0_after_drop", be_img[0], 8'h55);
    check_sb("img2");

    // Reset during the second HOLD cycle aborts the load.
    pulse_start(1'b1);
    send_beat(32'hCAFEF00D, 1'b0);
    send_beat(32'h0BADC0DE, 1'b1);
    repeat (3) cyc();
    chk("hold2_count", be_count, 5'd16);
    chk("hold2_cpu_rst", be_cpu_rst, 1'b1);
    chk("hold2_done", be_done, 1'b0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("abort_count", be_count, 5'd0);
    chk("abort_img", (be_img == '0 && le_img == '0), 1'b1);
    chk("abort_cpu_rst", be_cpu_rst, 1'b1);
    chk("abort_ready", be_ready, 1'b0);
    chk("abort_fwd", be_fwd, 1'b0);
    seen_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      seen_done = seen_done | be_done;
    end
    chk("abort_done_stays_low", seen_done, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
